// File: rtl/bcd_updown_multi_if.sv
// Bus bundle for the multi-digit BCD up/down counter: control strobes, load value,
// count and status outputs. The master modport drives the counter; slave is the counter side.
interface bcd_updown_multi_if #(
   parameter int NDIGITS = 2
);
   logic                   En;
   logic                   UpOrDown;
   logic                   Load;
   logic [4*NDIGITS-1:0]   LoadVal;
   logic                   OvfClr;
   logic [4*NDIGITS-1:0]   Count;
   logic                   Tc;
   logic                   CarryOut;
   logic                   BorrowOut;
   logic                   Ovf;
   logic                   LoadErr;

   modport master (
      output En, UpOrDown, Load, LoadVal, OvfClr,
      input  Count, Tc, CarryOut, BorrowOut, Ovf, LoadErr
   );

   modport slave (
      input  En, UpOrDown, Load, LoadVal, OvfClr,
      output Count, Tc, CarryOut, BorrowOut, Ovf, LoadErr
   );
endinterface

// File: rtl/bcd_updown_multi.sv
// Parametrised multi-digit BCD up/down counter with validated parallel load, wrap or
// saturate boundary handling, combinational terminal count and a sticky overflow flag.
module bcd_updown_multi #(
   parameter int NDIGITS  = 2,
   parameter bit SATURATE = 1'b0
) (
   input logic              Clk,
   input logic              reset,
   bcd_updown_multi_if.slave bus
);
   localparam int W = 4 * NDIGITS;

   logic [W-1:0] countQ, countD;
   logic         carryQ, carryD;
   logic         borrowQ, borrowD;
   logic         ovfQ, ovfD;
   logic         loadErrQ, loadErrD;
   logic         allNines, allZero;
   logic         ripple;
   logic [3:0]   dig;

   always_comb begin
      allNines = 1'b1;
      allZero  = 1'b1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (countQ[4*i +: 4] != 4'd9) allNines = 1'b0;
         if (countQ[4*i +: 4] != 4'd0) allZero  = 1'b0;
      end
   end

   // Digit i moves only while every lower digit sits at its rollover value, so the
   // whole count steps in a single cycle with no ripple between edges.
   always_comb begin
      countD   = countQ;
      carryD   = 1'b0;
      borrowD  = 1'b0;
      loadErrD = 1'b0;
      ovfD     = ovfQ & ~bus.OvfClr;
      ripple   = 1'b1;
      dig      = 4'd0;
      if (bus.Load) begin
         for (int i = 0; i < NDIGITS; i++) begin
            dig = bus.LoadVal[4*i +: 4];
            if (dig > 4'd9) begin
               dig      = 4'd9;
               loadErrD = 1'b1;
            end
            countD[4*i +: 4] = dig;
         end
      end else if (bus.En) begin
         if (bus.UpOrDown) begin
            if (allNines) begin
               ovfD = 1'b1;
               if (!SATURATE) begin
                  countD = '0;
                  carryD = 1'b1;
               end
            end else begin
               for (int i = 0; i < NDIGITS; i++) begin
                  dig = countQ[4*i +: 4];
                  if (ripple) countD[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                  ripple = ripple & (dig == 4'd9);
               end
            end
         end else begin
            if (allZero) begin
               ovfD = 1'b1;
               if (!SATURATE) begin
                  countD  = {NDIGITS{4'd9}};
                  borrowD = 1'b1;
               end
            end else begin
               for (int i = 0; i < NDIGITS; i++) begin
                  dig = countQ[4*i +: 4];
                  if (ripple) countD[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                  ripple = ripple & (dig == 4'd0);
               end
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         countQ   <= '0;
         carryQ   <= 1'b0;
         borrowQ  <= 1'b0;
         ovfQ     <= 1'b0;
         loadErrQ <= 1'b0;
      end else begin
         countQ   <= countD;
         carryQ   <= carryD;
         borrowQ  <= borrowD;
         ovfQ     <= ovfD;
         loadErrQ <= loadErrD;
      end
   end

   // Tc is left combinational so a higher-order instance can use it as En this cycle.
   assign bus.Tc        = bus.En & ~bus.Load &
                          ((allNines & bus.UpOrDown) | (allZero & ~bus.UpOrDown));
   assign bus.Count     = countQ;
   assign bus.CarryOut  = carryQ;
   assign bus.BorrowOut = borrowQ;
   assign bus.Ovf       = ovfQ;
   assign bus.LoadErr   = loadErrQ;
endmodule

// File: tb/tb_bcd_updown_multi.sv
// Directed testbench for bcd_updown_multi: a wrapping 2-digit instance and a
// saturating 2-digit instance, each scenario in its own task with hand-computed values.
module tb_bcd_updown_multi;
   logic Clk;
   logic reset;
   int   checks;
   int   failures;

   bcd_updown_multi_if #(.NDIGITS(2)) ifc0 ();
   bcd_updown_multi_if #(.NDIGITS(2)) ifc1 ();

   bcd_updown_multi #(.NDIGITS(2), .SATURATE(1'b0)) dutWrap (
      .Clk   (Clk),
      .reset (reset),
      .bus   (ifc0.slave)
   );

   bcd_updown_multi #(.NDIGITS(2), .SATURATE(1'b1)) dutSat (
      .Clk   (Clk),
      .reset (reset),
      .bus   (ifc1.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL rst_count got=%h exp=00", ifc0.Count); end
      checks++; if ({ifc0.CarryOut, ifc0.BorrowOut, ifc0.Ovf, ifc0.LoadErr} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_flags got=%b exp=0000", {ifc0.CarryOut, ifc0.BorrowOut, ifc0.Ovf, ifc0.LoadErr}); end
      @(negedge Clk);
      reset = 1'b1;
      ifc0.LoadVal = 8'h37;
      ifc0.Load = 1'b1;
      tick();
      checks++; if (ifc0.Count !== 8'h37) begin failures++; $display("[TB] FAIL load37 got=%h exp=37", ifc0.Count); end
      ifc0.Load = 1'b0;
      ifc0.En = 1'b1;
      ifc0.UpOrDown = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL async_rst got=%h exp=00", ifc0.Count); end
      @(negedge Clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      checks++; if (ifc0.Count !== 8'h12) begin failures++; $display("[TB] FAIL up12 got=%h exp=12", ifc0.Count); end
      checks++; if (ifc0.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL up12_ovf got=%b exp=0", ifc0.Ovf); end
      ifc0.En = 1'b0;
   endtask

   task automatic test_up_wrap();
      ifc0.LoadVal = 8'h98;
      ifc0.Load = 1'b1;
      tick();
      ifc0.Load = 1'b0;
      ifc0.En = 1'b1;
      ifc0.UpOrDown = 1'b1;
      #1;
      checks++; if (ifc0.Tc !== 1'b0) begin failures++; $display("[TB] FAIL tc_at98 got=%b exp=0", ifc0.Tc); end
      tick();
      checks++; if (ifc0.Count !== 8'h99) begin failures++; $display("[TB] FAIL upw_99 got=%h exp=99", ifc0.Count); end
      checks++; if (ifc0.CarryOut !== 1'b0) begin failures++; $display("[TB] FAIL upw_carry99 got=%b exp=0", ifc0.CarryOut); end
      checks++; if (ifc0.Tc !== 1'b1) begin failures++; $display("[TB] FAIL upw_tc got=%b exp=1", ifc0.Tc); end
      tick();
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL upw_00 got=%h exp=00", ifc0.Count); end
      checks++; if (ifc0.CarryOut !== 1'b1) begin failures++; $display("[TB] FAIL upw_carry got=%b exp=1", ifc0.CarryOut); end
      checks++; if (ifc0.Ovf !== 1'b1) begin failures++; $display("[TB] FAIL upw_ovf got=%b exp=1", ifc0.Ovf); end
      ifc0.En = 1'b0;
      tick();
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL upw_hold got=%h exp=00", ifc0.Count); end
      checks++; if (ifc0.CarryOut !== 1'b0) begin failures++; $display("[TB] FAIL upw_carry_off got=%b exp=0", ifc0.CarryOut); end
      checks++; if (ifc0.Ovf !== 1'b1) begin failures++; $display("[TB] FAIL upw_ovf_sticky got=%b exp=1", ifc0.Ovf); end
   endtask

   task automatic test_down_wrap();
      ifc0.LoadVal = 8'h01;
      ifc0.Load = 1'b1;
      ifc0.En = 1'b1;
      ifc0.UpOrDown = 1'b0;
      #1;
      checks++; if (ifc0.Tc !== 1'b0) begin failures++; $display("[TB] FAIL tc_load_mask got=%b exp=0", ifc0.Tc); end
      tick();
      ifc0.Load = 1'b0;
      tick();
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL dnw_00 got=%h exp=00", ifc0.Count); end
      checks++; if (ifc0.Tc !== 1'b1) begin failures++; $display("[TB] FAIL dnw_tc0 got=%b exp=1", ifc0.Tc); end
      tick();
      checks++; if (ifc0.Count !== 8'h99) begin failures++; $display("[TB] FAIL dnw_99 got=%h exp=99", ifc0.Count); end
      checks++; if (ifc0.BorrowOut !== 1'b1) begin failures++; $display("[TB] FAIL dnw_borrow got=%b exp=1", ifc0.BorrowOut); end
      checks++; if (ifc0.Tc !== 1'b0) begin failures++; $display("[TB] FAIL dnw_tc99_down got=%b exp=0", ifc0.Tc); end
      ifc0.UpOrDown = 1'b1;
      #1;
      checks++; if (ifc0.Tc !== 1'b1) begin failures++; $display("[TB] FAIL dnw_tc99_up got=%b exp=1", ifc0.Tc); end
      tick();
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL dir_00 got=%h exp=00", ifc0.Count); end
      checks++; if ({ifc0.CarryOut, ifc0.BorrowOut} !== 2'b10) begin failures++; $display("[TB] FAIL dir_pulses got=%b exp=10", {ifc0.CarryOut, ifc0.BorrowOut}); end
      ifc0.LoadVal = 8'h50;
      ifc0.Load = 1'b1;
      tick();
      ifc0.Load = 1'b0;
      ifc0.UpOrDown = 1'b0;
      tick();
      checks++; if (ifc0.Count !== 8'h49) begin failures++; $display("[TB] FAIL dn_borrow_chain got=%h exp=49", ifc0.Count); end
      ifc0.En = 1'b0;
   endtask

   task automatic test_saturate();
      ifc1.LoadVal = 8'h99;
      ifc1.Load = 1'b1;
      tick();
      ifc1.Load = 1'b0;
      ifc1.En = 1'b1;
      ifc1.UpOrDown = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ifc1.Count !== 8'h99) begin failures++; $display("[TB] FAIL sat_up_%0d got=%h exp=99", i, ifc1.Count); end
         checks++; if (ifc1.CarryOut !== 1'b0) begin failures++; $display("[TB] FAIL sat_carry_%0d got=%b exp=0", i, ifc1.CarryOut); end
      end
      checks++; if (ifc1.Ovf !== 1'b1) begin failures++; $display("[TB] FAIL sat_ovf got=%b exp=1", ifc1.Ovf); end
      ifc1.LoadVal = 8'h00;
      ifc1.Load = 1'b1;
      tick();
      ifc1.Load = 1'b0;
      ifc1.UpOrDown = 1'b0;
      tick();
      checks++; if (ifc1.Count !== 8'h00) begin failures++; $display("[TB] FAIL sat_dn got=%h exp=00", ifc1.Count); end
      checks++; if (ifc1.BorrowOut !== 1'b0) begin failures++; $display("[TB] FAIL sat_borrow got=%b exp=0", ifc1.BorrowOut); end
      ifc1.En = 1'b0;
   endtask

   task automatic test_load();
      ifc0.LoadVal = 8'hA5;
      ifc0.Load = 1'b1;
      ifc0.En = 1'b1;
      ifc0.UpOrDown = 1'b1;
      tick();
      checks++; if (ifc0.Count !== 8'h95) begin failures++; $display("[TB] FAIL ld_clamp got=%h exp=95", ifc0.Count); end
      checks++; if (ifc0.LoadErr !== 1'b1) begin failures++; $display("[TB] FAIL ld_err got=%b exp=1", ifc0.LoadErr); end
      ifc0.Load = 1'b0;
      ifc0.En = 1'b0;
      tick();
      checks++; if (ifc0.Count !== 8'h95) begin failures++; $display("[TB] FAIL ld_hold got=%h exp=95", ifc0.Count); end
      checks++; if (ifc0.LoadErr !== 1'b0) begin failures++; $display("[TB] FAIL ld_err_off got=%b exp=0", ifc0.LoadErr); end
      ifc0.LoadVal = 8'h3F;
      ifc0.Load = 1'b1;
      tick();
      checks++; if (ifc0.Count !== 8'h39) begin failures++; $display("[TB] FAIL ld_clamp_lo got=%h exp=39", ifc0.Count); end
      checks++; if (ifc0.LoadErr !== 1'b1) begin failures++; $display("[TB] FAIL ld_err_lo got=%b exp=1", ifc0.LoadErr); end
      ifc0.LoadVal = 8'h42;
      tick();
      checks++; if (ifc0.Count !== 8'h42) begin failures++; $display("[TB] FAIL ld_valid got=%h exp=42", ifc0.Count); end
      checks++; if (ifc0.LoadErr !== 1'b0) begin failures++; $display("[TB] FAIL ld_valid_err got=%b exp=0", ifc0.LoadErr); end
      ifc0.Load = 1'b0;
   endtask

   task automatic test_ovf_clear();
      checks++; if (ifc0.Ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_pre got=%b exp=1", ifc0.Ovf); end
      ifc0.LoadVal = 8'h99;
      ifc0.Load = 1'b1;
      tick();
      ifc0.Load = 1'b0;
      ifc0.En = 1'b1;
      ifc0.UpOrDown = 1'b1;
      ifc0.OvfClr = 1'b1;
      tick();
      checks++; if (ifc0.Ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_collide got=%b exp=1", ifc0.Ovf); end
      checks++; if (ifc0.Count !== 8'h00) begin failures++; $display("[TB] FAIL ovf_wrap got=%h exp=00", ifc0.Count); end
      ifc0.En = 1'b0;
      tick();
      checks++; if (ifc0.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clr got=%b exp=0", ifc0.Ovf); end
      ifc0.OvfClr = 1'b0;
      tick();
      checks++; if (ifc0.Ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_stay_clr got=%b exp=0", ifc0.Ovf); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      ifc0.En = 1'b0; ifc0.UpOrDown = 1'b1; ifc0.Load = 1'b0; ifc0.LoadVal = '0; ifc0.OvfClr = 1'b0;
      ifc1.En = 1'b0; ifc1.UpOrDown = 1'b1; ifc1.Load = 1'b0; ifc1.LoadVal = '0; ifc1.OvfClr = 1'b0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load();
      test_ovf_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
